// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the single-issue MIPS core: sequences fetch, decode,
// execute, memory and write-back, driving every datapath enable and mux select.
module mc_ctrl #(
  parameter logic [4:0]  RA_ADDR = 5'd31,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             dm_ready,
  output logic [2:0]       state,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             grf_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             ext_op,
  output logic             dm_re,
  output logic             dm_we,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic is_r, op_addu, op_subu, op_jr, op_nop;
  logic op_ori, op_lui, op_lw, op_sw, op_beq, op_jal, supported;

  always_comb begin
    is_r      = (opcode == 6'b000000);
    op_addu   = is_r && (funct == 6'b100001);
    op_subu   = is_r && (funct == 6'b100011);
    op_jr     = is_r && (funct == 6'b001000);
    op_nop    = is_r && (funct == 6'b000000);
    op_ori    = (opcode == 6'b001101);
    op_lui    = (opcode == 6'b001111);
    op_lw     = (opcode == 6'b100011);
    op_sw     = (opcode == 6'b101011);
    op_beq    = (opcode == 6'b000100);
    op_jal    = (opcode == 6'b000011);
    supported = op_addu | op_subu | op_jr | op_nop | op_ori | op_lui |
                op_lw | op_sw | op_beq | op_jal;
  end

  always_comb begin
    state_d = FETCH;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    npc_sel = 2'd0;
    grf_we  = 1'b0;
    reg_dst = 2'd0;
    wd_sel  = 2'd0;
    alu_src = 1'b0;
    alu_op  = 2'd0;
    ext_op  = 1'b0;
    dm_re   = 1'b0;
    dm_we   = 1'b0;
    illegal = 1'b0;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (op_nop)          retire  = 1'b1;
        else if (!supported) illegal = 1'b1;
        else                 state_d = EXEC;
      end
      EXEC: begin
        if (op_addu || op_subu) begin
          alu_op  = op_subu ? 2'd1 : 2'd0;
          state_d = WB;
        end else if (op_ori) begin
          alu_src = 1'b1;
          alu_op  = 2'd2;
          state_d = WB;
        end else if (op_lui) begin
          alu_src = 1'b1;
          alu_op  = 2'd3;
          state_d = WB;
        end else if (op_lw || op_sw) begin
          alu_src = 1'b1;
          ext_op  = 1'b1;
          state_d = MEM;
        end else if (op_beq) begin
          alu_op  = 2'd1;
          pc_we   = zero;
          npc_sel = {1'b0, zero};
          retire  = 1'b1;
        end else if (op_jal) begin
          pc_we   = 1'b1;
          npc_sel = 2'd2;
          grf_we  = 1'b1;
          reg_dst = 2'd2;
          wd_sel  = 2'd2;
          retire  = 1'b1;
        end else if (op_jr) begin
          pc_we   = 1'b1;
          npc_sel = 2'd3;
          retire  = 1'b1;
        end
      end
      MEM: begin
        // Address selects stay stable for the whole memory access.
        if (op_lw || op_sw) begin
          alu_src = 1'b1;
          ext_op  = 1'b1;
          dm_re   = op_lw;
          dm_we   = op_sw;
          if (!dm_ready)  state_d = MEM;
          else if (op_lw) state_d = WB;
          else            retire  = 1'b1;
        end
      end
      WB: begin
        grf_we = 1'b1;
        retire = 1'b1;
        if (op_addu || op_subu) begin
          reg_dst = 2'd1;
          alu_op  = op_subu ? 2'd1 : 2'd0;
        end else if (op_ori) begin
          alu_src = 1'b1;
          alu_op  = 2'd2;
        end else if (op_lui) begin
          alu_src = 1'b1;
          alu_op  = 2'd3;
        end else if (op_lw) begin
          alu_src = 1'b1;
          ext_op  = 1'b1;
          wd_sel  = 2'd1;
        end
      end
      default: state_d = FETCH;
    endcase
    // Reset must silence every strobe at once, independent of the clock.
    if (!reset) begin
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      npc_sel = 2'd0;
      grf_we  = 1'b0;
      reg_dst = 2'd0;
      wd_sel  = 2'd0;
      alu_src = 1'b0;
      alu_op  = 2'd0;
      ext_op  = 1'b0;
      dm_re   = 1'b0;
      dm_we   = 1'b0;
      illegal = 1'b0;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle and
// compares state plus the packed control vector against hand-computed values.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, dm_ready;
  logic [2:0]  state;
  logic        ir_we, pc_we, grf_we, alu_src, ext_op, dm_re, dm_we, illegal;
  logic [1:0]  npc_sel, reg_dst, wd_sel, alu_op;
  logic [31:0] retired;
  logic [15:0] ctl;

  int errors  = 0;
  int checks  = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  // [15]ir_we [14]pc_we [13:12]npc_sel [11]grf_we [10:9]reg_dst [8:7]wd_sel
  // [6]alu_src [5:4]alu_op [3]ext_op [2]dm_re [1]dm_we [0]illegal
  assign ctl = {ir_we, pc_we, npc_sel, grf_we, reg_dst, wd_sel,
                alu_src, alu_op, ext_op, dm_re, dm_we, illegal};

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .dm_ready(dm_ready), .state(state), .ir_we(ir_we), .pc_we(pc_we),
    .npc_sel(npc_sel), .grf_we(grf_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .dm_re(dm_re),
    .dm_we(dm_we), .illegal(illegal), .retired(retired)
  );

  task automatic test_reset();
    reset = 1'b0; opcode = 6'b001101; funct = 6'd0; zero = 1'b0; dm_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if ({state, ctl} !== 19'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", {state, ctl}, 19'd0);
    end
    checks++;
    if (retired !== 32'd0) begin
      errors++; $display("FAIL reset_retired: got %0d want 0", retired);
    end
    checks++;
    reset = 1'b1;
    #1;
    if ({state, ctl} !== {3'd0, 16'hC000}) begin
      errors++; $display("FAIL reset_release: got %h want %h", {state, ctl}, {3'd0, 16'hC000});
    end
    checks++;
  endtask

  task automatic test_ori();
    logic [18:0] exp [5] = '{{3'd0, 16'hC000}, {3'd1, 16'h0000}, {3'd2, 16'h0060},
                             {3'd4, 16'h0860}, {3'd0, 16'hC000}};
    opcode = 6'b001101; funct = 6'd0; dm_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if ({state, ctl} !== exp[i]) begin
        errors++; $display("FAIL ori cyc%0d: got %h want %h", i, {state, ctl}, exp[i]);
      end
      checks++;
      if (i < 4) begin @(posedge clk); #1; end
    end
    exp_ret++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL ori_retired: got %0d want %0d", retired, exp_ret);
    end
    checks++;
  endtask

  task automatic test_lui();
    logic [18:0] exp [5] = '{{3'd0, 16'hC000}, {3'd1, 16'h0000}, {3'd2, 16'h0070},
                             {3'd4, 16'h0870}, {3'd0, 16'hC000}};
    opcode = 6'b001111; funct = 6'd0;
    for (int i = 0; i < 5; i++) begin
      if ({state, ctl} !== exp[i]) begin
        errors++; $display("FAIL lui cyc%0d: got %h want %h", i, {state, ctl}, exp[i]);
      end
      checks++;
      if (i < 4) begin @(posedge clk); #1; end
    end
    exp_ret++;
  endtask

  task automatic test_addu_subu();
    logic [18:0] exp_a [5] = '{{3'd0, 16'hC000}, {3'd1, 16'h0000}, {3'd2, 16'h0000},
                               {3'd4, 16'h0A00}, {3'd0, 16'hC000}};
    logic [18:0] exp_s [5] = '{{3'd0, 16'hC000}, {3'd1, 16'h0000}, {3'd2, 16'h0010},
                               {3'd4, 16'h0A10}, {3'd0, 16'hC000}};
    opcode = 6'b000000; funct = 6'b100001;
    for (int i = 0; i < 5; i++) begin
      if ({state, ctl} !== exp_a[i]) begin
        errors++; $display("FAIL addu cyc%0d: got %h want %h", i, {state, ctl}, exp_a[i]);
      end
      checks++;
      if (i < 4) begin @(posedge clk); #1; end
    end
    funct = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      if ({state, ctl} !== exp_s[i]) begin
        errors++; $display("FAIL subu cyc%0d: got %h want %h", i, {state, ctl}, exp_s[i]);
      end
      checks++;
      if (i < 4) begin @(posedge clk); #1; end
    end
    exp_ret += 2;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL alu_retired: got %0d want %0d", retired, exp_ret);
    end
    checks++;
  endtask

  task automatic test_nop();
    logic [18:0] exp [3] = '{{3'd0, 16'hC000}, {3'd1, 16'h0000}, {3'd0, 16'hC000}};
    opcode = 6'b000000; funct = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      if ({state, ctl} !== exp[i]) begin
        errors++; $display("FAIL nop cyc%0d: got %h want %h", i, {state, ctl}, exp[i]);
      end
      checks++;
      if (i < 2) begin @(posedge clk); #1; end
    end
    exp_ret++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL nop_retired: got %0d want %0d", retired, exp_ret);
    end
    checks++;
  endtask

  task automatic test_lw_wait();
    logic [18:0] exp [8] = '{{3'd0, 16'hC000}, {3'd1, 16'h0000}, {3'd2, 16'h0048},
                             {3'd3, 16'h004C}, {3'd3, 16'h004C}, {3'd3, 16'h004C},
                             {3'd4, 16'h08C8}, {3'd0, 16'hC000}};
    opcode = 6'b100011; funct = 6'd0;
    for (int i = 0; i < 8; i++) begin
      dm_ready = (i < 3 || i > 4);
      #1;
      if ({state, ctl} !== exp[i]) begin
        errors++; $display("FAIL lw_wait cyc%0d: got %h want %h", i, {state, ctl}, exp[i]);
      end
      checks++;
      if (i < 7) begin @(posedge clk); #1; end
    end
    exp_ret++;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL lw_retired: got %0d want %0d", retired, exp_ret);
    end
    checks++;
  endtask

  task automatic test_sw();
    logic [18:0] exp [5] = '{{3'd0, 16'hC000}, {3'd1, 16'h0000}, {3'd2, 16'h0048},
                             {3'd3, 16'h004A}, {3'd0, 16'hC000}};
    opcode = 6'b101011; funct = 6'd0; dm_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if ({state, ctl} !== exp[i]) begin
        errors++; $display("FAIL sw cyc%0d: got %h want %h", i, {state, ctl}, exp[i]);
      end
      checks++;
      if (i < 4) begin @(posedge clk); #1; end
    end
    exp_ret++;
  endtask

  task automatic test_beq();
    logic [18:0] exp_t [4] = '{{3'd0, 16'hC000}, {3'd1, 16'h0000}, {3'd2, 16'h5010},
                               {3'd0, 16'hC000}};
    logic [18:0] exp_n [4] = '{{3'd0, 16'hC000}, {3'd1, 16'h0000}, {3'd2, 16'h0010},
                               {3'd0, 16'hC000}};
    opcode = 6'b000100; funct = 6'd0; zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if ({state, ctl} !== exp_t[i]) begin
        errors++; $display("FAIL beq_taken cyc%0d: got %h want %h", i, {state, ctl}, exp_t[i]);
      end
      checks++;
      if (i < 3) begin @(posedge clk); #1; end
    end
    zero = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if ({state, ctl} !== exp_n[i]) begin
        errors++; $display("FAIL beq_not cyc%0d: got %h want %h", i, {state, ctl}, exp_n[i]);
      end
      checks++;
      if (i < 3) begin @(posedge clk); #1; end
    end
    exp_ret += 2;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL beq_retired: got %0d want %0d", retired, exp_ret);
    end
    checks++;
  endtask

  task automatic test_jal_jr();
    logic [18:0] exp_j [4] = '{{3'd0, 16'hC000}, {3'd1, 16'h0000}, {3'd2, 16'h6D00},
                               {3'd0, 16'hC000}};
    logic [18:0] exp_r [4] = '{{3'd0, 16'hC000}, {3'd1, 16'h0000}, {3'd2, 16'h7000},
                               {3'd0, 16'hC000}};
    opcode = 6'b000011; funct = 6'd0;
    for (int i = 0; i < 4; i++) begin
      if ({state, ctl} !== exp_j[i]) begin
        errors++; $display("FAIL jal cyc%0d: got %h want %h", i, {state, ctl}, exp_j[i]);
      end
      checks++;
      if (i < 3) begin @(posedge clk); #1; end
    end
    opcode = 6'b000000; funct = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      if ({state, ctl} !== exp_r[i]) begin
        errors++; $display("FAIL jr cyc%0d: got %h want %h", i, {state, ctl}, exp_r[i]);
      end
      checks++;
      if (i < 3) begin @(posedge clk); #1; end
    end
    exp_ret += 2;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL jal_jr_retired: got %0d want %0d", retired, exp_ret);
    end
    checks++;
  endtask

  task automatic test_illegal();
    logic [18:0] exp [3] = '{{3'd0, 16'hC000}, {3'd1, 16'h0001}, {3'd0, 16'hC000}};
    opcode = 6'b111111; funct = 6'd0;
    for (int i = 0; i < 3; i++) begin
      if ({state, ctl} !== exp[i]) begin
        errors++; $display("FAIL illegal_op cyc%0d: got %h want %h", i, {state, ctl}, exp[i]);
      end
      checks++;
      if (i < 2) begin @(posedge clk); #1; end
    end
    opcode = 6'b000000; funct = 6'b100000;
    for (int i = 0; i < 3; i++) begin
      if ({state, ctl} !== exp[i]) begin
        errors++; $display("FAIL illegal_fn cyc%0d: got %h want %h", i, {state, ctl}, exp[i]);
      end
      checks++;
      if (i < 2) begin @(posedge clk); #1; end
    end
    if (retired !== exp_ret) begin
      errors++; $display("FAIL illegal_retired: got %0d want %0d", retired, exp_ret);
    end
    checks++;
  endtask

  task automatic test_abort();
    logic [18:0] exp [4] = '{{3'd0, 16'hC000}, {3'd1, 16'h0000}, {3'd2, 16'h0048},
                             {3'd3, 16'h004A}};
    opcode = 6'b101011; funct = 6'd0; dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ({state, ctl} !== exp[i]) begin
        errors++; $display("FAIL abort_seq cyc%0d: got %h want %h", i, {state, ctl}, exp[i]);
      end
      checks++;
      if (i < 3) begin @(posedge clk); #1; end
    end
    #1 reset = 1'b0;
    #1;
    if ({state, ctl} !== 19'd0) begin
      errors++; $display("FAIL abort_outputs: got %h want %h", {state, ctl}, 19'd0);
    end
    checks++;
    exp_ret = 0;
    if (retired !== exp_ret) begin
      errors++; $display("FAIL abort_retired: got %0d want 0", retired);
    end
    checks++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    if ({state, ctl} !== {3'd0, 16'hC000}) begin
      errors++; $display("FAIL abort_release: got %h want %h", {state, ctl}, {3'd0, 16'hC000});
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_ori();
    test_lui();
    test_addu_subu();
    test_nop();
    test_lw_wait();
    test_sw();
    test_beq();
    test_jal_jr();
    test_illegal();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
